pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor.
- Next generation of the team's 8-bit ripple adder (sum = A + B + cin, WIDTH+1-bit result).
- Splits the carry chain into CHUNK-bit stages, one register stage per chunk.
- Adds an add/subtract mode, a signed-overflow flag, and a valid/ready handshake with backpressure.
- Sits between operand producers and datapath consumers that need a registered, throttleable arithmetic result.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).
- CHUNK, 4, bits resolved per pipeline stage (1..WIDTH).
- STAGES is derived as ceil(WIDTH/CHUNK); the last chunk may be narrower.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in in add mode; borrow-in in subtract mode.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH+1  result; sum[WIDTH] is carry-out (subtract: 1 = no borrow).
- overflow  out  1  signed overflow of sum[WIDTH-1:0].

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: all outputs except in_ready are 0, and every stage valid bit is cleared. in_ready is 1 during the cycle after reset.
- Operand transform at acceptance:
  - b_eff = sub ? ~b : b.
  - c0 = cin ^ sub.
  - sub=1, cin=0 gives A-B. sub=1, cin=1 gives A-B-1.
- Acceptance occurs when in_valid && in_ready. a, b_eff, c0 and sub are captured into stage 0.
- Stage k (0..STAGES-1):
  - Adds bits [k*CHUNK +: CHUNK] (clipped to WIDTH) of a and b_eff plus the incoming carry.
  - Registers the partial result bits, the outgoing carry, the remaining unprocessed operand bits and a valid bit.
  - Already-computed low bits ride along unchanged.
- Output register after the final stage:
  - sum = {carry_out, result[WIDTH-1:0]}.
  - overflow = (a[MSB] == b_eff[MSB]) && (result[MSB] != a[MSB]), using the operand MSBs carried through the pipe.
- Latency: exactly STAGES+1 clk edges from the accepting edge to out_valid=1 when unstalled (WIDTH=8, CHUNK=4: 3 cycles).
- Throughput: one operation per cycle.
- Backpressure is a global stall:
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every stage register and the output register hold, and no new operands are accepted.
  - Bubbles are not compressed.
- Output hold: sum, overflow and out_valid stay stable while out_valid && !out_ready.
- Handshake:
  - out_valid drops on the edge after the transfer unless the next result arrives on that edge.
  - in_valid may be held without acceptance; the block never captures when in_ready=0.
- Simultaneous output transfer and input acceptance in the same cycle is legal and loses nothing.
- Reset mid-operation discards all in-flight results. out_valid is 0 the following cycle, with no partial results emitted.
- CHUNK >= WIDTH degenerates to a single adder stage plus the output register (latency 2).
- Width rules:
  - No truncation.
  - Arithmetic is modulo 2^(WIDTH+1) on the {carry, result} pair.
  - Carry-out wraps only through sum[WIDTH].

Test Plan:
- WIDTH=8, CHUNK=4, add: A=FF, B=FF, cin=0 -> sum=1FE, overflow=0, out_valid exactly 3 cycles after acceptance.
- Add, back-to-back on consecutive cycles with out_ready=1:
  - A=79, B=69 -> sum=0E2, overflow=1.
  - A=79, B=6B -> sum=0E4, overflow=1.
  - Both results emitted on consecutive cycles.
- Subtract:
  - A=05, B=07, cin=0 -> sum=0FE (carry 0 = borrow), overflow=0.
  - A=80, B=01 -> sum=17F, overflow=1.
  - A=07, B=05, cin=1 -> sum=101.
- Backpressure:
  - Stream 4 additions, hold out_ready=0 for 5 cycles after the first out_valid.
  - in_ready=0 throughout the stall; sum holds constant.
  - On release, all 4 results arrive in order, none lost or duplicated.
- Reset mid-flight: assert rst one cycle after accepting 2 operations -> out_valid stays 0, next result appears only for post-reset inputs.
- WIDTH=16, CHUNK=5 (ragged last chunk): A=FFFF, B=0001, cin=1 -> sum=10001 after 5 cycles; 1000 random add/sub vectors match a reference model.

Source files
------------

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: pipelined two's-complement adder/subtractor.
//   The carry chain is split into CHUNK-bit stages (STAGES = ceil(WIDTH/CHUNK)),
//   one register stage per chunk, followed by an output register.
//   Latency is STAGES+1 register edges, counting the accepting edge.
//   Throughput is one operation per cycle. Backpressure stalls the whole pipe.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready = !stall)
//   a, b                WIDTH-bit operands
//   cin                 carry-in (add) / borrow-in (subtract)
//   sub                 0 = a + b + cin, 1 = a - b - cin
//   out_valid/out_ready result handshake
//   sum                 {carry_out, result}; in subtract mode carry 1 = no borrow
//   overflow            signed overflow of sum[WIDTH-1:0]

// One chunk of the carry chain. It adds bits [LO +: W] of a and b plus the
// incoming carry and splices the partial sum into the running result.
module pipelined_addsub_stage #(
  parameter int WIDTH = 8,
  parameter int LO    = 0,
  parameter int W     = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] r_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] r_out,
  output logic             c_out
);
  logic [W:0] s;
  // Only this stage's slice of the operands is consumed here.
  logic unused_ok;

  assign unused_ok = ^{a, b};
  assign s = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]} + {{W{1'b0}}, c_in};
  assign c_out = s[W];

  always_comb begin
    r_out = r_in;
    r_out[LO +: W] = s[W-1:0];
  end
endmodule

module pipelined_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             overflow
);
  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

  logic             stall, accept, c0;
  logic [WIDTH-1:0] b_eff;
  // vld_pipe[k] is stage k's valid bit; vld_pipe[STAGES] is the output register.
  logic [STAGES:0]  vld_pipe;

  // *_q: stage registers. *_src: what each stage consumes (the previous
  // stage's registers, or the transformed inputs for stage 0).
  // *_nx: combinational stage outputs.
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, r_q, a_src, b_src, r_src, r_nx;
  logic [STAGES-1:0]            c_q, c_src, c_nx;
  logic                         unused_ok;

  assign b_eff     = sub ? ~b : b;
  assign c0        = cin ^ sub;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_pipe[STAGES];

  // The last stage needs only the operand MSBs, for overflow.
  assign unused_ok = ^{a_q[STAGES-1][WIDTH-2:0], b_q[STAGES-1][WIDTH-2:0]};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int W  = (WIDTH - LO < CHUNK) ? WIDTH - LO : CHUNK;

    if (k == 0) begin : g_first
      assign a_src[k] = a;
      assign b_src[k] = b_eff;
      assign r_src[k] = '0;
      assign c_src[k] = c0;
    end else begin : g_rest
      assign a_src[k] = a_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign r_src[k] = r_q[k-1];
      assign c_src[k] = c_q[k-1];
    end

    pipelined_addsub_stage #(.WIDTH(WIDTH), .LO(LO), .W(W)) u_stage (
      .a     (a_src[k]),
      .b     (b_src[k]),
      .r_in  (r_src[k]),
      .c_in  (c_src[k]),
      .r_out (r_nx[k]),
      .c_out (c_nx[k])
    );
  end

  // A stall freezes every register, so bubbles stay where they are.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      sum      <= '0;
      overflow <= 1'b0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
      a_q      <= a_src;
      b_q      <= b_src;
      r_q      <= r_nx;
      c_q      <= c_nx;
      sum      <= {c_q[STAGES-1], r_q[STAGES-1]};
      // Operands of equal sign that produce a result of the other sign.
      overflow <= (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                  (r_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub. Instance 0 is WIDTH=8/CHUNK=4 and instance 1
// is WIDTH=16/CHUNK=5. Expected results come from an arithmetic model and are
// queued at acceptance. They are checked in order when a result transfers.
module tb_pipelined_addsub;
  typedef struct packed {
    logic [16:0] sum;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  iv, ir, ov, ordy, ci, sb, ovf;
  logic [15:0] a_d [2];
  logic [15:0] b_d [2];
  logic [8:0]  s0;
  logic [16:0] s1;

  exp_t        q0[$];
  exp_t        q1[$];
  logic        held [2] = '{1'b0, 1'b0};
  logic [16:0] hsum [2];
  logic        hovf [2];
  logic        done;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(8), .CHUNK(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_d[0][7:0]), .b(b_d[0][7:0]), .cin(ci[0]), .sub(sb[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .overflow(ovf[0])
  );

  pipelined_addsub #(.WIDTH(16), .CHUNK(5)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_d[1]), .b(b_d[1]), .cin(ci[1]), .sub(sb[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .overflow(ovf[1])
  );

  // Reference: sum is a + (sub ? 2^W-1-b : b) + (cin^sub), modulo 2^(W+1).
  // Overflow means the true signed value a +/- b +/- cin leaves the W-bit range.
  function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic c, input logic s);
    exp_t   e;
    int     wd   = (w == 1) ? 16 : 8;
    longint m    = (longint'(1) << wd) - 1;
    longint h    = longint'(1) << (wd - 1);
    longint ua   = longint'(av) & m;
    longint ub   = longint'(bv) & m;
    longint beff = s ? (m - ub) : ub;
    longint raw  = ua + beff + longint'(c ^ s);
    longint sa   = (ua >= h) ? ua - 2 * h : ua;
    longint sbv  = (ub >= h) ? ub - 2 * h : ub;
    longint v    = s ? (sa - sbv - longint'(c)) : (sa + sbv + longint'(c));
    e.sum = 17'(raw & ((m << 1) | 1));
    e.ovf = (v >= h) || (v < -h);
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Offers one operand set. It returns on the accepting edge and queues the
  // expected result.
  task automatic send(input int w, input logic [15:0] av, input logic [15:0] bv,
                      input logic c, input logic s);
    int   n = 0;
    logic acc;
    #1;
    iv[w] = 1'b1; a_d[w] = av; b_d[w] = bv; ci[w] = c; sb[w] = s;
    do begin
      @(negedge clk); acc = ir[w];
      @(posedge clk); n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 0, 1);
    else if (w == 0) q0.push_back(model(w, av, bv, c, s));
    else q1.push_back(model(w, av, bv, c, s));
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(posedge clk); n++;
    end
    chk("drain_left", q0.size() + q1.size(), 0);
  endtask

  task automatic mon(input int w);
    logic [16:0] s;
    exp_t        e;
    s = (w == 1) ? s1 : {8'b0, s0};
    if (held[w]) begin
      chk("hold_valid", ov[w], 1);
      chk("hold_sum", s, hsum[w]);
      chk("hold_ovf", ovf[w], hovf[w]);
    end
    if (ov[w] && ordy[w]) begin
      if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) chk("unexpected_out", 1, 0);
      else begin
        if (w == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk((w == 0) ? "sum8" : "sum16", s, e.sum);
        chk((w == 0) ? "ovf8" : "ovf16", ovf[w], e.ovf);
      end
    end
    held[w] = ov[w] && !ordy[w];
    if (held[w]) begin
      hsum[w] = s; hovf[w] = ovf[w];
      chk("stall_in_ready", ir[w], 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; iv = '0; ordy = '1; ci = '0; sb = '0; done = 1'b0;
    a_d[0] = '0; a_d[1] = '0; b_d[0] = '0; b_d[1] = '0;

    // Pin the model against hand-computed values.
    chk("pin_ffff",  model(0, 16'hFF, 16'hFF, 0, 0), {17'h1FE, 1'b0});
    chk("pin_7969",  model(0, 16'h79, 16'h69, 0, 0), {17'h0E2, 1'b1});
    chk("pin_0507",  model(0, 16'h05, 16'h07, 0, 1), {17'h0FE, 1'b0});
    chk("pin_8001",  model(0, 16'h80, 16'h01, 0, 1), {17'h17F, 1'b1});
    chk("pin_0705",  model(0, 16'h07, 16'h05, 1, 1), {17'h101, 1'b0});
    chk("pin_16",    model(1, 16'hFFFF, 16'h0001, 1, 0), {17'h10001, 1'b0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ov", ov, 0);
    chk("rst_ir", ir, 2'b11);
    chk("rst_s0", s0, 0);
    chk("rst_s1", s1, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Latency, 8-bit: 3 edges counting the accepting one.
    send(0, 16'hFF, 16'hFF, 0, 0); #1 iv[0] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); chk("lat8", ov[0], (i == 3) ? 1 : 0);
    end

    // Back-to-back: results on consecutive cycles.
    @(posedge clk);
    send(0, 16'h79, 16'h69, 0, 0);
    send(0, 16'h79, 16'h6B, 0, 0); #1 iv[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); chk("b2b_valid", ov[0], (i == 2 || i == 3) ? 1 : 0);
    end

    // Subtract cases.
    @(posedge clk);
    send(0, 16'h05, 16'h07, 0, 1);
    send(0, 16'h80, 16'h01, 0, 1);
    send(0, 16'h07, 16'h05, 1, 1); #1 iv[0] = 1'b0;
    drain();

    // Backpressure: four adds, consumer stalls for 5 cycles at first result.
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 16'(8'h30 + i * 8'h11), 16'(8'h41 + i), 0, 0);
        #1 iv[0] = 1'b0;
      end
      begin
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!ov[0] && n < 50);
        chk("bp_first_valid", ov[0], 1);
        ordy[0] = 1'b0;
        repeat (5) begin
          @(negedge clk); chk("bp_in_ready", ir[0], 0);
          @(posedge clk);
        end
        #1 ordy[0] = 1'b1;
      end
    join
    drain();

    // Reset one cycle after two acceptances: nothing may emerge.
    @(posedge clk);
    send(0, 16'h11, 16'h22, 0, 0);
    send(0, 16'h33, 16'h44, 0, 0);
    #1 iv[0] = 1'b0; rst = 1'b1; q0.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("post_rst_ir", ir[0], 1);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_ov", ov[0], 0);
      @(negedge clk);
    end
    @(posedge clk);
    send(0, 16'h12, 16'h34, 0, 0); #1 iv[0] = 1'b0;
    drain();

    // Latency, 16-bit/ragged chunks: 5 edges.
    @(posedge clk);
    send(1, 16'hFFFF, 16'h0001, 1, 0); #1 iv[1] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); chk("lat16", ov[1], (i == 5) ? 1 : 0);
    end
    @(posedge clk);

    // Random traffic on both instances with random consumer stalls.
    fork
      begin
        fork
          begin
            for (int i = 0; i < 1000; i++) begin
              if ($urandom_range(0, 3) == 0) begin #1 iv[1] = 1'b0; @(posedge clk); end
              send(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            #1 iv[1] = 1'b0;
          end
          begin
            for (int i = 0; i < 300; i++) begin
              if ($urandom_range(0, 3) == 0) begin #1 iv[0] = 1'b0; @(posedge clk); end
              send(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            #1 iv[0] = 1'b0;
          end
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ordy[0] = ($urandom_range(0, 3) != 0);
          ordy[1] = ($urandom_range(0, 3) != 0);
        end
        ordy = '1;
      end
    join
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
